// File: rtl/zet_shrot_seq_if.sv
// Handshake and operand bus between the microcode sequencer and the
// multi-cycle shift/rotate sequencer.
interface zet_shrot_seq_if;
  logic        start;
  logic [2:0]  func;
  logic        word;
  logic [15:0] x;
  logic [7:0]  cnt;
  logic        cfi;
  logic        ofi;
  logic [15:0] o;
  logic        cfo;
  logic        ofo;
  logic        busy;
  logic        done;

  // Sequencer side: issues operations and collects results.
  modport master (
    output start, func, word, x, cnt, cfi, ofi,
    input  o, cfo, ofo, busy, done
  );

  // Shifter side.
  modport slave (
    input  start, func, word, x, cnt, cfi, ofi,
    output o, cfo, ofo, busy, done
  );
endinterface

// File: rtl/zet_shrot_seq.sv
// Zet ALU shift/rotate sequencer: ROL/ROR/RCL/RCR/SHL/SHR/SAR on an 8- or
// 16-bit operand, one bit position per clock, count masked to 5 bits.
module zet_shrot_seq (
  input  logic               clk,
  input  logic               rst_n,
  zet_shrot_seq_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] F_ROL = 3'd0;
  localparam logic [2:0] F_ROR = 3'd1;
  localparam logic [2:0] F_RCL = 3'd2;
  localparam logic [2:0] F_RCR = 3'd3;
  localparam logic [2:0] F_SAR = 3'd7;
  localparam logic [2:0] F_SHR = 3'd5;

  // One single-bit step. Returns {carry_out, next_r}. In byte mode the
  // upper half of r passes through untouched.
  function automatic logic [16:0] shift_step(
    input logic [2:0]  f,
    input logic        wd,
    input logic [15:0] r,
    input logic        c
  );
    logic        msb;
    logic        fill;
    logic        cn;
    logic [15:0] rn;
    msb = wd ? r[15] : r[7];
    if (f[0] == 1'b0) begin
      // Left family: ROL, RCL, SHL, SAL.
      cn = msb;
      case (f)
        F_ROL:   fill = msb;
        F_RCL:   fill = c;
        default: fill = 1'b0;
      endcase
      if (wd) rn = {r[14:0], fill};
      else    rn = {r[15:8], r[6:0], fill};
    end else begin
      // Right family: ROR, RCR, SHR, SAR.
      cn = r[0];
      case (f)
        F_ROR:   fill = r[0];
        F_RCR:   fill = c;
        F_SAR:   fill = msb;
        default: fill = 1'b0;
      endcase
      if (wd) rn = {fill, r[15:1]};
      else    rn = {r[15:8], fill, r[7:1]};
    end
    return {cn, rn};
  endfunction

  // Overflow flag for a non-zero count, from the final value and carry.
  function automatic logic calc_of(
    input logic [2:0]  f,
    input logic        wd,
    input logic [15:0] r,
    input logic        c,
    input logic        msb0
  );
    logic msb;
    logic nxt;
    logic of;
    msb = wd ? r[15] : r[7];
    nxt = wd ? r[14] : r[6];
    case (f)
      F_ROR, F_RCR: of = msb ^ nxt;
      F_SHR:        of = msb0;
      F_SAR:        of = 1'b0;
      default:      of = msb ^ c;
    endcase
    return of;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  func_q,  func_d;
  logic        word_q,  word_d;
  logic [15:0] r_q,     r_d;
  logic        c_q,     c_d;
  logic        ofi_q,   ofi_d;
  logic        msb0_q,  msb0_d;
  logic        zero_q,  zero_d;
  logic [4:0]  rem_q,   rem_d;
  logic [15:0] o_q,     o_d;
  logic        cfo_q,   cfo_d;
  logic        ofo_q,   ofo_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;

  logic [16:0] step;
  logic [4:0]  rem_dec;

  assign step    = shift_step(func_q, word_q, r_q, c_q);
  assign rem_dec = rem_q - 5'd1;

  // Next-state, operand latch, stepping and result capture.
  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    word_d  = word_q;
    r_d     = r_q;
    c_d     = c_q;
    ofi_d   = ofi_q;
    msb0_d  = msb0_q;
    zero_d  = zero_q;
    rem_d   = rem_q;
    o_d     = o_q;
    cfo_d   = cfo_q;
    ofo_d   = ofo_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      SHIFT: begin
        if (rem_q == 5'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
          o_d     = r_q;
          cfo_d   = c_q;
          ofo_d   = zero_q ? ofi_q : calc_of(func_q, word_q, r_q, c_q, msb0_q);
        end else begin
          r_d    = step[15:0];
          c_d    = step[16];
          rem_d  = rem_dec;
          busy_d = (rem_dec != 5'd0);
        end
      end
      default: begin
        // IDLE and DONE both accept a new operation.
        if (bus.start) begin
          state_d = SHIFT;
          func_d  = bus.func;
          word_d  = bus.word;
          r_d     = bus.x;
          c_d     = bus.cfi;
          ofi_d   = bus.ofi;
          msb0_d  = bus.word ? bus.x[15] : bus.x[7];
          rem_d   = bus.cnt[4:0];
          zero_d  = (bus.cnt[4:0] == 5'd0);
          busy_d  = (bus.cnt[4:0] != 5'd0);
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      func_q  <= 3'd0;
      word_q  <= 1'b0;
      r_q     <= 16'd0;
      c_q     <= 1'b0;
      ofi_q   <= 1'b0;
      msb0_q  <= 1'b0;
      zero_q  <= 1'b0;
      rem_q   <= 5'd0;
      o_q     <= 16'd0;
      cfo_q   <= 1'b0;
      ofo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      word_q  <= word_d;
      r_q     <= r_d;
      c_q     <= c_d;
      ofi_q   <= ofi_d;
      msb0_q  <= msb0_d;
      zero_q  <= zero_d;
      rem_q   <= rem_d;
      o_q     <= o_d;
      cfo_q   <= cfo_d;
      ofo_q   <= ofo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.o    = o_q;
  assign bus.cfo  = cfo_q;
  assign bus.ofo  = ofo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_zet_shrot_seq.sv
// Directed and randomized bench for the shift/rotate sequencer with a
// queue-based scoreboard of expected results.
module tb_zet_shrot_seq;

  typedef struct packed {
    logic [15:0] o;
    logic        cfo;
    logic        ofo;
  } res_t;

  logic clk;
  logic rst_n;
  zet_shrot_seq_if bus();

  zet_shrot_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Independent reference: bit-by-bit shifting with masks on a w-bit field.
  function automatic res_t ref_model(input logic [2:0] f, input logic wd,
                                     input logic [15:0] xv, input logic [7:0] cv,
                                     input logic ci, input logic oi);
    res_t        r;
    int          n;
    int          w;
    logic [15:0] mask;
    logic [15:0] v;
    logic        c;
    logic        m0;
    logic        top;
    logic        bot;
    n    = int'(cv[4:0]);
    w    = wd ? 16 : 8;
    mask = wd ? 16'hFFFF : 16'h00FF;
    v    = xv & mask;
    c    = ci;
    m0   = v[w-1];
    if (n == 0) begin
      r.o = xv; r.cfo = ci; r.ofo = oi;
      return r;
    end
    for (int i = 0; i < n; i++) begin
      top = v[w-1];
      bot = v[0];
      case (f)
        3'd0: begin v = ((v << 1) | {15'd0, top}) & mask; c = top; end
        3'd1: begin v = (v >> 1) | ({15'd0, bot} << (w-1)); c = bot; end
        3'd2: begin v = ((v << 1) | {15'd0, c}) & mask; c = top; end
        3'd3: begin v = (v >> 1) | ({15'd0, c} << (w-1)); c = bot; end
        3'd5: begin v = v >> 1; c = bot; end
        3'd7: begin v = (v >> 1) | ({15'd0, top} << (w-1)); c = bot; end
        default: begin v = (v << 1) & mask; c = top; end
      endcase
    end
    r.o   = (xv & ~mask) | v;
    r.cfo = c;
    case (f)
      3'd1, 3'd3: r.ofo = v[w-1] ^ v[w-2];
      3'd5:       r.ofo = m0;
      3'd7:       r.ofo = 1'b0;
      default:    r.ofo = v[w-1] ^ c;
    endcase
    return r;
  endfunction

  // Drive an operation with start high; the next rising edge is E0.
  task automatic issue(input logic [2:0] f, input logic wd, input logic [15:0] xv,
                       input logic [7:0] cv, input logic ci, input logic oi);
    bus.func  = f;
    bus.word  = wd;
    bus.x     = xv;
    bus.cnt   = cv;
    bus.cfi   = ci;
    bus.ofi   = oi;
    bus.start = 1'b1;
  endtask

  // Clock through E0, wait (bounded) for done, check latency/busy/result.
  task automatic finish_op(input int n, input string tag);
    int   k;
    int   bc;
    res_t e;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k  = 0;
    bc = int'(bus.busy);
    while (!bus.done && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (!bus.done) bc += int'(bus.busy);
    end
    chk({tag, "_latency"}, k, n + 1);
    chk({tag, "_busy_cycles"}, bc, n);
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_o"},   bus.o,   e.o);
      chk({tag, "_cfo"}, bus.cfo, e.cfo);
      chk({tag, "_ofo"}, bus.ofo, e.ofo);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_o"},    bus.o,    16'h0);
    chk({tag, "_cfo"},  bus.cfo,  1'b0);
    chk({tag, "_ofo"},  bus.ofo,  1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_done"}, bus.done, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rf;
    logic        rw;
    logic [15:0] rx;
    logic [7:0]  rc;
    logic        rci;
    logic        roi;
    int          done_seen;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.func = 3'd0; bus.word = 1'b0; bus.x = 16'h0;
    bus.cnt = 8'h0; bus.cfi = 1'b0; bus.ofi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SHL word by 1.
    issue(3'd4, 1'b1, 16'h8001, 8'd1, 1'b0, 1'b0);
    exp_q.push_back('{16'h0002, 1'b1, 1'b1});
    finish_op(1, "shl_w1");
    @(posedge clk); #1;
    chk("done_single_pulse", bus.done, 1'b0);
    chk("result_hold", bus.o, 16'h0002);

    // ROL word by 4.
    issue(3'd0, 1'b1, 16'h1234, 8'd4, 1'b0, 1'b0);
    exp_q.push_back('{16'h2341, 1'b1, 1'b1});
    finish_op(4, "rol_w4");

    // RCR byte by 1, then back-to-back SAR byte, then back-to-back cnt=0x20.
    issue(3'd3, 1'b0, 16'hAB01, 8'd1, 1'b1, 1'b0);
    exp_q.push_back('{16'hAB80, 1'b1, 1'b1});
    finish_op(1, "rcr_b1");
    issue(3'd7, 1'b0, 16'h0080, 8'd7, 1'b0, 1'b0);
    exp_q.push_back('{16'h00FF, 1'b0, 1'b0});
    finish_op(7, "sar_b7_b2b");
    issue(3'd1, 1'b1, 16'h5A5A, 8'h20, 1'b1, 1'b0);
    exp_q.push_back('{16'h5A5A, 1'b1, 1'b0});
    finish_op(0, "cnt20_b2b");
    @(posedge clk); #1;
    chk("cnt20_done_drop", bus.done, 1'b0);
    chk("cnt20_busy_idle", bus.busy, 1'b0);

    // RCL byte by 9 returns the original operand and carry.
    issue(3'd2, 1'b0, 16'h00C3, 8'd9, 1'b0, 1'b0);
    exp_q.push_back('{16'h00C3, 1'b0, 1'b1});
    finish_op(9, "rcl_b9");

    // SHR word by 16: second start ignored, then reset mid-shift.
    issue(3'd5, 1'b1, 16'hFFFF, 8'd16, 1'b0, 1'b0);
    @(posedge clk); #1;              // E0
    bus.start = 1'b0;
    chk("shr16_busy_e0", bus.busy, 1'b1);
    @(posedge clk); #1;              // E1
    bus.start = 1'b1; bus.x = 16'h0000; bus.cnt = 8'd0;
    @(posedge clk); #1;              // E2
    bus.start = 1'b0;
    chk("start_ignored_busy", bus.busy, 1'b1);
    chk("start_ignored_done", bus.done, 1'b0);
    @(posedge clk);                  // E3
    @(posedge clk);                  // E4
    @(posedge clk);                  // E5
    #2;
    rst_n = 1'b0;
    #1;
    chk_cleared("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      done_seen += int'(bus.done);
    end
    chk("no_done_after_reset", done_seen, 0);
    chk("busy_after_reset", bus.busy, 1'b0);

    // Randomized operations, issued back-to-back in each DONE cycle.
    for (int i = 0; i < 8; i++) begin
      rf  = 3'($urandom_range(0, 7));
      rw  = 1'($urandom_range(0, 1));
      rx  = 16'($urandom);
      rc  = 8'($urandom_range(0, 255));
      rci = 1'($urandom_range(0, 1));
      roi = 1'($urandom_range(0, 1));
      issue(rf, rw, rx, rc, rci, roi);
      exp_q.push_back(ref_model(rf, rw, rx, rc, rci, roi));
      finish_op(int'(rc[4:0]), $sformatf("rand%0d_f%0d_w%0d", i, rf, rw));
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
